// File: rtl/spi_mem_bridge.sv
// SPI frame command decoder bridging a 16-bit SPI word port to the sdram_controller host port.
// Decodes register reads, memory writes and memory reads; stages responses in tx_data.
module spi_mem_bridge #(
   parameter logic [15:0] ID_WORD    = 16'hB5A0,
   parameter int unsigned RD_TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [15:0] rx_data,
   output logic [15:0] tx_data,
   output logic [31:0] mem_wr_addr,
   output logic [15:0] mem_wr_data,
   output logic        mem_wr_enable,
   output logic [31:0] mem_rd_addr,
   output logic        mem_rd_enable,
   input  logic [15:0] mem_rd_data,
   input  logic        mem_rd_ready,
   input  logic        mem_busy
);

   localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR_LO, ADDR_HI, WR_DATA, WR_ISSUE, RD_ISSUE, RD_WAIT
   } state_t;

   state_t        state;
   logic          is_write;
   logic [31:0]   addr_q;
   logic [15:0]   data_q;
   logic [7:0]    err_cnt;
   logic [15:0]   wr_cnt;
   logic [15:0]   rd_last;
   logic          timeout_f;
   logic          overrun_f;
   logic          rd_valid_f;
   logic [TW-1:0] timer;
   logic [15:0]   reg_rd_c;

   // Register file read mux, indexed by the low byte of the command frame
   always_comb begin
      reg_rd_c = 16'h0000;
      case (rx_data[7:0])
         8'h00:   reg_rd_c = ID_WORD;
         8'h01:   reg_rd_c = {err_cnt, 5'b0, timeout_f, overrun_f, rd_valid_f};
         8'h02:   reg_rd_c = rd_last;
         8'h03:   reg_rd_c = wr_cnt;
         default: reg_rd_c = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         is_write      <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         err_cnt       <= '0;
         wr_cnt        <= '0;
         rd_last       <= '0;
         timeout_f     <= 1'b0;
         overrun_f     <= 1'b0;
         rd_valid_f    <= 1'b0;
         timer         <= '0;
         tx_data       <= '0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
         mem_wr_enable <= 1'b0;
         mem_rd_addr   <= '0;
         mem_rd_enable <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_data[15:8] == 8'h80) begin
                     tx_data <= reg_rd_c;
                     if (rx_data[7:0] == 8'h01) begin
                        timeout_f <= 1'b0;
                        overrun_f <= 1'b0;
                     end
                  end else if (rx_data == 16'hC000 || rx_data == 16'hC100) begin
                     is_write <= rx_data[8];
                     state    <= ADDR_LO;
                  end else if (err_cnt != 8'hFF) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
               end
            end
            ADDR_LO: begin
               if (rx_valid) begin
                  addr_q[15:0] <= rx_data;
                  state        <= ADDR_HI;
               end
            end
            ADDR_HI: begin
               if (rx_valid) begin
                  addr_q[31:16] <= rx_data;
                  if (is_write) begin
                     state <= WR_DATA;
                  end else begin
                     // Issue straight away when the controller is free
                     state <= RD_ISSUE;
                     if (!mem_busy) begin
                        mem_rd_enable <= 1'b1;
                        mem_rd_addr   <= {rx_data, addr_q[15:0]};
                     end
                  end
               end
            end
            WR_DATA: begin
               if (rx_valid) begin
                  data_q <= rx_data;
                  state  <= WR_ISSUE;
                  if (!mem_busy) begin
                     mem_wr_enable <= 1'b1;
                     mem_wr_addr   <= addr_q;
                     mem_wr_data   <= rx_data;
                     wr_cnt        <= wr_cnt + 16'd1;
                  end
               end
            end
            WR_ISSUE: begin
               if (rx_valid) overrun_f <= 1'b1;
               if (mem_wr_enable) begin
                  mem_wr_enable <= 1'b0;
                  state         <= IDLE;
               end else if (!mem_busy) begin
                  mem_wr_enable <= 1'b1;
                  mem_wr_addr   <= addr_q;
                  mem_wr_data   <= data_q;
                  wr_cnt        <= wr_cnt + 16'd1;
               end
            end
            RD_ISSUE: begin
               if (rx_valid) overrun_f <= 1'b1;
               if (mem_rd_enable) begin
                  mem_rd_enable <= 1'b0;
                  timer         <= '0;
                  state         <= RD_WAIT;
               end else if (!mem_busy) begin
                  mem_rd_enable <= 1'b1;
                  mem_rd_addr   <= addr_q;
               end
            end
            RD_WAIT: begin
               if (rx_valid) overrun_f <= 1'b1;
               if (mem_rd_ready) begin
                  rd_last    <= mem_rd_data;
                  tx_data    <= mem_rd_data;
                  rd_valid_f <= 1'b1;
                  state      <= IDLE;
               end else if (timer == TIMER_LAST) begin
                  tx_data   <= 16'hDEAD;
                  timeout_f <= 1'b1;
                  state     <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

Command decoder between the SPI slave's 16-bit word port and the sdram_controller host port. Parses one 16-bit frame per SPI chip-select cycle into register reads, memory writes and memory reads. Issues single-cycle wr_enable/rd_enable pulses to the controller and stages the response word for the next SPI exchange.

## Interface
Parameters:
- ID_WORD, 16'hB5A0, constant returned by register 0x00
- RD_TIMEOUT, 256, cycles to wait for rd_ready before abort (≥2)

Ports:
- clk  in  1  system clock, shared with sdram_controller
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a complete received frame
- rx_data  in  16  received frame
- tx_data  out  16  word the SPI slave shifts out on the next frame; sampled by the slave at CS falling edge
- mem_wr_addr  out  32  to controller wr_addr
- mem_wr_data  out  16  to controller wr_data
- mem_wr_enable  out  1  one-cycle write request
- mem_rd_addr  out  32  to controller rd_addr
- mem_rd_enable  out  1  one-cycle read request
- mem_rd_data  in  16  from controller rd_data
- mem_rd_ready  in  1  read data valid
- mem_busy  in  1  controller cannot accept a request

## Operation
- Commands (first frame in IDLE):
  - 16'h80AA: register read. tx_data <= reg[AA]; stay IDLE.
  - 16'hC000: memory read. Next two frames: addr[15:0], addr[31:16]; then the read is issued.
  - 16'hC100: memory write. Next three frames: addr[15:0], addr[31:16], data; then the write is issued.
  - Anything else: ignored; err_cnt (8-bit, saturating) increments.
- Registers (8-bit index; unmapped indices read 16'h0000):
  - 0x00: ID_WORD.
  - 0x01: status {8'(err_cnt), 5'b0, timeout, overrun, rd_valid}. Reading it clears timeout and overrun.
  - 0x02: last read data.
  - 0x03: write count (16-bit, wraps).
- States: IDLE, ADDR_LO, ADDR_HI, WR_DATA, WR_ISSUE, RD_ISSUE, RD_WAIT.
  - IDLE→ADDR_LO on a C000/C100 frame; opcode latched.
  - ADDR_LO→ADDR_HI on the next frame.
  - ADDR_HI→WR_DATA (write) or RD_ISSUE (read) on the next frame.
  - WR_DATA→WR_ISSUE on the next frame.
  - WR_ISSUE: when mem_busy=0, pulse mem_wr_enable for exactly one cycle with addr/data stable; write count +1; →IDLE.
  - RD_ISSUE: when mem_busy=0, pulse mem_rd_enable for one cycle; clear timer; →RD_WAIT.
  - RD_WAIT: on the first cycle mem_rd_ready=1, capture mem_rd_data into reg 0x02 and tx_data, set rd_valid, →IDLE. If the timer reaches RD_TIMEOUT first, tx_data <= 16'hDEAD, set timeout, →IDLE.
- A frame that arrives while in WR_ISSUE/RD_ISSUE/RD_WAIT is dropped and sets overrun. It is not decoded.
- rx_valid is sampled only in IDLE/ADDR_LO/ADDR_HI/WR_DATA.
- tx_data holds its value until explicitly reloaded. Memory writes and address/data frames do not change it.
- mem_*_addr/mem_wr_data hold their last values between requests.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; err_cnt, write count, flags and reg 0x02 all 0.
- Register read: tx_data valid 1 cycle after the rx_valid of the command frame.
- Write: mem_wr_enable asserts 1 cycle after the data-frame rx_valid if mem_busy=0. Otherwise it asserts on the first cycle after mem_busy falls. No timeout on busy.
- Read: mem_rd_enable asserts 1 cycle after the addr-hi rx_valid if not busy. tx_data is updated the cycle after mem_rd_ready.
- Read data returns on the next SPI frame after completion. The host must allow one frame gap (≥1 µs at a 50 MHz clk).
- mem_rd_ready already high at issue time is ignored. Capture only from the cycle after the mem_rd_enable pulse.
- rx_valid coincident with a state transition is evaluated against the current state.
- Reset mid-operation aborts immediately. Any pending request is lost, and no enable pulse is emitted after reset release.

## Test plan
- Frame 16'h8000, then read tx_data → 16'hB5A0 one cycle after rx_valid; frame 16'h8055 → 16'h0000.
- Frames C100, 0000, 0000, 1234 with mem_busy=0 → single mem_wr_enable pulse, mem_wr_addr=0, mem_wr_data=16'h1234; reg 0x03 reads 1.
- Frames C100, 000A, 0000, 7777 with mem_busy held high 50 cycles → pulse exactly on the cycle after busy falls, addr=10, data=16'h7777.
- Frames C000, 000A, 0000; model returns 16'h7777 with rd_ready 8 cycles later → tx_data=16'h7777, reg 0x02=16'h7777, status bit0=1.
- Read with mem_rd_ready never asserted → tx_data=16'hDEAD after RD_TIMEOUT cycles, status bit2=1; a second 16'h8001 read shows bit2 cleared.
- Frame 16'h1111 → err_cnt=1. A frame sent during RD_WAIT → overrun=1, no decode. rst asserted during WR_ISSUE → no mem_wr_enable, all outputs 0.
